// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stage-register controls of the pipeline
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             i_mem_req_mem;
    logic             i_mem_ack;
    logic             i_mem_rden_ex;
    logic             i_rd_wren_ex;
    logic [4:0]       i_rd_ex;
    logic [4:0]       i_rs1_id;
    logic [4:0]       i_rs2_id;
    logic             i_rs1_used_id;
    logic             i_rs2_used_id;
    logic             i_pc_sel_ex;
    logic             o_enable_pc;
    logic             o_enable_if;
    logic             o_enable_id;
    logic             o_enable_ex;
    logic             o_enable_mem;
    logic             o_flush_n_if;
    logic             o_flush_n_id;
    logic             o_flush_n_mem;
    logic             o_mem_err;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_mem_req_mem, i_mem_ack, i_mem_rden_ex, i_rd_wren_ex, i_rd_ex,
               i_rs1_id, i_rs2_id, i_rs1_used_id, i_rs2_used_id, i_pc_sel_ex,
        input  o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
               o_flush_n_if, o_flush_n_id, o_flush_n_mem, o_mem_err, o_stall_cnt
    );

    modport slave (
        input  i_mem_req_mem, i_mem_ack, i_mem_rden_ex, i_rd_wren_ex, i_rd_ex,
               i_rs1_id, i_rs2_id, i_rs1_used_id, i_rs2_used_id, i_pc_sel_ex,
        output o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
               o_flush_n_if, o_flush_n_id, o_flush_n_mem, o_mem_err, o_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic               i_clk,
    input logic               i_rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          memstall, load_use, live, hold, branch;

    // hazard detection and stage control, all same-cycle
    always_comb begin
        memstall = bus.i_mem_req_mem & ~bus.i_mem_ack;
        load_use = bus.i_mem_rden_ex & bus.i_rd_wren_ex & (bus.i_rd_ex != 5'd0) &
                   ((bus.i_rs1_used_id & (bus.i_rs1_id == bus.i_rd_ex)) |
                    (bus.i_rs2_used_id & (bus.i_rs2_id == bus.i_rd_ex)));
        live     = i_rst & (state != ERR);
        hold     = live & ~memstall;
        branch   = bus.i_pc_sel_ex;
        bus.o_enable_pc   = hold & (branch | ~load_use);
        bus.o_enable_if   = hold & (branch | ~load_use);
        bus.o_enable_id   = hold;
        bus.o_enable_ex   = hold;
        bus.o_enable_mem  = hold;
        bus.o_flush_n_if  = live & ~(hold & branch);
        bus.o_flush_n_id  = live & ~(hold & (branch | load_use));
        bus.o_flush_n_mem = hold;
        bus.o_mem_err     = state == ERR;
    end

    // memory wait sequencing; ack or a dropped request both end the wait
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN:      if (memstall) begin
                          state_nxt = MEM_WAIT;
                          wcnt_nxt  = WW'(1);
                      end
            MEM_WAIT: if (!memstall) begin
                          state_nxt = RUN;
                          wcnt_nxt  = '0;
                      end else if (wcnt == WLAST) state_nxt = ERR;
                      else wcnt_nxt = wcnt + 1'b1;
            default:  state_nxt = ERR;
        endcase
    end

    // state register; ERR is left only through reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // saturating count of cycles where the PC is held
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) bus.o_stall_cnt <= '0;
        else if (!bus.o_enable_pc && bus.o_stall_cnt != '1) bus.o_stall_cnt <= bus.o_stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random stimulus against a cycle-level reference model
module tb_pipe_hazard_ctrl;
    localparam int TMO = 16;
    localparam int CW  = 8;

    logic i_clk = 0;
    logic i_rst = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_cnt = 0;
    int   m_wait = 0;
    bit   m_err = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // one clock: drive, compare at negedge, advance model at posedge
    task automatic tick(input logic rn, input logic req, input logic ack, input logic rden,
                        input logic wren, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2, input logic sel);
        logic       ms, lu;
        logic [8:0] exp, got;
        i_rst = rn;
        bus.i_mem_req_mem = req;  bus.i_mem_ack = ack;
        bus.i_mem_rden_ex = rden; bus.i_rd_wren_ex = wren; bus.i_rd_ex = rd;
        bus.i_rs1_id = rs1; bus.i_rs2_id = rs2;
        bus.i_rs1_used_id = u1; bus.i_rs2_used_id = u2; bus.i_pc_sel_ex = sel;
        if (!rn) begin
            m_err = 0; m_wait = 0; m_cnt = 0;
        end
        ms = req && !ack;
        lu = rden && wren && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        // order: pc if id ex mem | flush_if flush_id flush_mem | err
        if (!rn)       exp = 9'b00000_000_0;
        else if (m_err) exp = 9'b00000_000_1;
        else if (ms)   exp = 9'b00000_110_0;
        else if (sel)  exp = 9'b11111_001_0;
        else if (lu)   exp = 9'b00111_101_0;
        else           exp = 9'b11111_111_0;
        @(negedge i_clk);
        got = {bus.o_enable_pc, bus.o_enable_if, bus.o_enable_id, bus.o_enable_ex, bus.o_enable_mem,
               bus.o_flush_n_if, bus.o_flush_n_id, bus.o_flush_n_mem, bus.o_mem_err};
        check("ctl", 32'(got), 32'(exp));
        check("stall_cnt", 32'(bus.o_stall_cnt), 32'(m_cnt));
        @(posedge i_clk);
        if (rn) begin
            if (!exp[8] && m_cnt < (1 << CW) - 1) m_cnt++;
            if (!m_err) begin
                if (ms) begin
                    m_wait++;
                    if (m_wait >= TMO) m_err = 1;
                end else m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] pick_reg();
        int r = $urandom_range(0, 3);
        return r == 0 ? 5'd0 : r == 1 ? 5'd5 : r == 2 ? 5'd7 : 5'($urandom);
    endfunction

    initial begin
        logic req;
        req = 0;
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 1, 1, 5, 5, 5, 1, 1, 1);
        idle(10);
        tick(1, 0, 0, 1, 1, 5, 0, 5, 0, 1, 0);
        idle(1);
        tick(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0);
        tick(1, 0, 0, 1, 1, 5, 5, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1, 1, 5, 5, 0, 1, 0, 1);
        tick(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < TMO + 3; i++) tick(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        tick(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) tick(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) req = ~req;
            tick($urandom_range(0, 799) != 0, req, $urandom_range(0, 3) == 0,
                 1'($urandom), 1'($urandom), pick_reg(), pick_reg(), pick_reg(),
                 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives the enable and active-low synchronous-clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves three hazard sources:
- multi-cycle data-memory access (req/ack wait, with timeout);
- load-use dependency;
- taken branch/jump resolved in EX.

Keeps saturating stall statistics.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles for mem_ack before error (>=2)
CNT_W, 32, width of stall statistic counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-low reset
i_mem_req_mem  in  1  load/store occupying MEM stage
i_mem_ack  in  1  data memory completes access this cycle
i_mem_rden_ex  in  1  instruction in EX is a load
i_rd_wren_ex  in  1  EX instruction writes rd
i_rd_ex  in  5  EX destination register
i_rs1_id  in  5  ID source 1
i_rs2_id  in  5  ID source 2
i_rs1_used_id  in  1  ID reads rs1
i_rs2_used_id  in  1  ID reads rs2
i_pc_sel_ex  in  1  taken branch/jump resolved in EX
o_enable_pc  out  1  PC register enable
o_enable_if  out  1  IF/ID enable
o_enable_id  out  1  ID/EX enable
o_enable_ex  out  1  EX/MEM enable
o_enable_mem  out  1  MEM/WB enable
o_flush_n_if  out  1  IF/ID sync clear (0 = insert NOP 0x00000013)
o_flush_n_id  out  1  ID/EX sync clear
o_flush_n_mem  out  1  MEM/WB sync clear
o_mem_err  out  1  sticky memory timeout flag
o_stall_cnt  out  CNT_W  cycles with o_enable_pc=0, saturating

Behaviour:
- States: RUN, MEM_WAIT, ERR. Wait counter wcnt sized clog2(MEM_TIMEOUT)+1.
- i_rst low (async):
  - state=RUN, wcnt=0, o_mem_err=0, o_stall_cnt=0.
  - All enables 0. All flush_n 0.
- Enables and flushes are combinational from state and inputs (same-cycle stall). Default is all enables 1 and all flush_n 1.
- Priority 1, memory stall: condition memstall = i_mem_req_mem & ~i_mem_ack, in RUN or MEM_WAIT.
  - All five enables 0.
  - o_flush_n_mem=0, so a bubble enters WB and no instruction retires twice.
  - Branch and load-use are ignored; they re-evaluate once the stall releases.
- Priority 2, branch: i_pc_sel_ex=1 with no memstall.
  - o_flush_n_if=0 and o_flush_n_id=0 (kill the 2 wrong-path instructions).
  - All enables 1. The PC loads the target.
  - Load-use is suppressed.
- Priority 3, load-use: trigger is i_mem_rden_ex & i_rd_wren_ex & i_rd_ex!=0 & ((i_rs1_used_id & i_rs1_id==i_rd_ex) | (i_rs2_used_id & i_rs2_id==i_rd_ex)).
  - o_enable_pc=0 and o_enable_if=0.
  - o_flush_n_id=0 (bubble into EX).
  - o_enable_id, o_enable_ex and o_enable_mem stay 1.
  - Exactly 1 stall cycle per hazard.
- Transitions:
  - RUN: memstall -> MEM_WAIT, wcnt=1.
  - MEM_WAIT:
    - ack -> RUN, wcnt=0. Enables are 1 that cycle and MEM/WB captures load data.
    - Else if wcnt==MEM_TIMEOUT-1 -> ERR.
    - Else wcnt+1.
  - Request dropped without ack while in MEM_WAIT -> RUN, wcnt=0.
  - ERR: all enables 0, all flush_n 0, o_mem_err=1. Only i_rst exits ERR.
- Request with ack in the same cycle (single-cycle access): no stall, stays in RUN.
- o_stall_cnt increments on every post-reset cycle with o_enable_pc=0, including in ERR. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-MEM_WAIT: outputs go to reset values immediately. No ack is remembered.

Test Plan:
- Reset release, no hazards -> all enables 1, flush_n 1, o_stall_cnt=0 for 10 cycles.
- Load x5 in EX, ID reads rs2=x5 -> 1 cycle with pc/if enables 0 and flush_n_id=0; o_stall_cnt=1. Repeat with rd=x0 -> no stall.
- Load-use and i_pc_sel_ex in the same cycle -> flush_n_if=flush_n_id=0, enable_pc=1, o_stall_cnt unchanged.
- mem_req with ack arriving after 3 cycles -> 3 cycles all enables 0 and flush_n_mem=0, then enable_mem=1 on the ack cycle; o_stall_cnt=3.
- mem_req with no ack, MEM_TIMEOUT=16 -> ERR after 16 stalled cycles; o_mem_err=1 and enables stay 0. i_rst pulse clears to RUN.
- i_rst low at wait cycle 2 -> outputs reset asynchronously, wcnt=0; after release, state RUN with o_mem_err=0.
